// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic_pkg
// Purpose  : Shared state encodings, OCW2 command codes and ICW/OCW bit
//            positions for the 8259A-style control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pic_pkg;

    typedef enum logic [2:0] {
        S_ICW1  = 3'd0,
        S_ICW2  = 3'd1,
        S_ICW3  = 3'd2,
        S_ICW4  = 3'd3,
        S_READY = 3'd4
    } cfg_state_t;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_P1   = 2'd1,
        A_GAP  = 2'd2,
        A_P2   = 2'd3
    } ack_state_t;

    // OCW2 command field, bits [7:5] (R, SL, EOI)
    localparam logic [2:0] NON_SPECIFIC_EOI   = 3'b001;
    localparam logic [2:0] SPECIFIC_EOI       = 3'b011;
    localparam logic [2:0] AUTOMATIC_ROTATING = 3'b101;
    localparam logic [2:0] SPECIFIC_ROTATING  = 3'b111;

    localparam int ICW1_IC4   = 0;
    localparam int ICW1_SNGL  = 1;
    localparam int ICW1_LTIM  = 3;
    localparam int ICW1_SEL   = 4;
    localparam int ICW4_AEOI  = 1;
    localparam int OCW2_EOI   = 5;
    localparam int OCW3_RIS   = 0;
    localparam int OCW3_RR    = 1;
    localparam int OCW3_SEL   = 3;

    function automatic logic op_is_eoi(input logic [7:0] op);
        return op[7:5] inside {NON_SPECIFIC_EOI, SPECIFIC_EOI,
                               AUTOMATIC_ROTATING, SPECIFIC_ROTATING};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pic_inta_sync.sv
`default_nettype none
// ============================================================================
// Module   : pic_inta_sync
// Purpose  : Synchronises the asynchronous active-low INTA and flags its
//            falling and rising edges in the clk domain.
// Revision : 1.0 - initial release
// ============================================================================
module pic_inta_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inta_n,
    output logic inta_s,
    output logic inta_fall,
    output logic inta_rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], inta_n};
        prev_d = sync_q[STAGES-1];
    end

    // Reset to the idle (high) level so no false edge appears after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign inta_s    = sync_q[STAGES-1];
    assign inta_fall = prev_q & ~inta_s;
    assign inta_rise = ~prev_q & inta_s;

endmodule
`default_nettype wire

// File: rtl/pic_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pic_control_sequencer
// Purpose  : ICW/OCW command decoder and two-pulse INTA sequencer for an
//            8259A-style priority resolver. Option macro: PIC_AUTO_EOI_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pic_control_sequencer
    import pic_pkg::*;
#(
    parameter int         INTA_SYNC_STAGES = 2,
    parameter logic [7:0] RESET_IMR        = 8'hFF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CS,
    input  logic       WR,
    input  logic       RD,
    input  logic       A0,
    input  logic [7:0] D_IN,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    input  logic       INTA,
    input  logic       INT_REQ,
    input  logic [2:0] INT_VEC,
    input  logic [7:0] IRR_IN,
    input  logic [7:0] ISR_IN,
    output logic [7:0] IM,
    output logic [7:0] OPERATION,
    output logic       INT,
    output logic       INIT_DONE
);

    cfg_state_t cfg_state_q, cfg_state_d;
    ack_state_t ack_state_q, ack_state_d;
    logic [4:0] t_q, t_d;
    logic       ltim_q, ltim_d;
    logic       sngl_q, sngl_d;
    logic       ic4_q, ic4_d;
    logic       aeoi_q, aeoi_d;
    logic       rr_q, rr_d;
    logic       ris_q, ris_d;
    logic [7:0] im_q, im_d;
    logic [7:0] operation_q, operation_d;
    logic [7:0] d_out_q, d_out_d;
    logic       d_oe_q, d_oe_d;
    logic       int_q, int_d;

    logic w_wr;
    logic w_icw1;
    logic w_init_done;
    logic w_read;
    logic w_inta_s;
    logic w_inta_fall;
    logic w_inta_rise;

    pic_inta_sync #(
        .STAGES (INTA_SYNC_STAGES)
    ) u_inta_sync (
        .clk       (CLK),
        .rst       (RESET),
        .inta_n    (INTA),
        .inta_s    (w_inta_s),
        .inta_fall (w_inta_fall),
        .inta_rise (w_inta_rise)
    );

    assign w_wr        = CS & WR;
    assign w_icw1      = w_wr & ~A0 & D_IN[ICW1_SEL];
    assign w_init_done = (cfg_state_q == S_READY);

    // ---------------- state register ----------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cfg_state_q <= S_ICW1;
            ack_state_q <= A_IDLE;
            t_q         <= '0;
            ltim_q      <= 1'b0;
            sngl_q      <= 1'b0;
            ic4_q       <= 1'b0;
            aeoi_q      <= 1'b0;
            rr_q        <= 1'b0;
            ris_q       <= 1'b0;
            im_q        <= RESET_IMR;
            operation_q <= '0;
            d_out_q     <= '0;
            d_oe_q      <= 1'b0;
            int_q       <= 1'b0;
        end else begin
            cfg_state_q <= cfg_state_d;
            ack_state_q <= ack_state_d;
            t_q         <= t_d;
            ltim_q      <= ltim_d;
            sngl_q      <= sngl_d;
            ic4_q       <= ic4_d;
            aeoi_q      <= aeoi_d;
            rr_q        <= rr_d;
            ris_q       <= ris_d;
            im_q        <= im_d;
            operation_q <= operation_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            int_q       <= int_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        cfg_state_d = cfg_state_q;
        if (w_icw1) begin
            cfg_state_d = S_ICW2;
        end else if (w_wr && A0) begin
            unique case (cfg_state_q)
                S_ICW2:  cfg_state_d = !sngl_q ? S_ICW3 : (ic4_q ? S_ICW4 : S_READY);
                S_ICW3:  cfg_state_d = ic4_q ? S_ICW4 : S_READY;
                S_ICW4:  cfg_state_d = S_READY;
                default: cfg_state_d = cfg_state_q;
            endcase
        end
    end

    always_comb begin
        ack_state_d = ack_state_q;
        if (w_icw1) begin
            ack_state_d = A_IDLE;
        end else if (w_init_done) begin
            unique case (ack_state_q)
                A_IDLE:  if (w_inta_fall) ack_state_d = A_P1;
                A_P1:    if (w_inta_rise) ack_state_d = A_GAP;
                A_GAP:   if (w_inta_fall) ack_state_d = A_P2;
                A_P2:    if (w_inta_rise) ack_state_d = A_IDLE;
                default: ack_state_d = A_IDLE;
            endcase
        end
    end

    // ---------------- command registers ----------------
    always_comb begin
        t_d    = t_q;
        ltim_d = ltim_q;
        sngl_d = sngl_q;
        ic4_d  = ic4_q;
        aeoi_d = aeoi_q;
        rr_d   = rr_q;
        ris_d  = ris_q;
        im_d   = im_q;

        // EOI is a one-cycle pulse so back-to-back EOIs remain distinct
        operation_d = operation_q;
        if (op_is_eoi(operation_q)) begin
            operation_d[OCW2_EOI] = 1'b0;
        end
`ifdef PIC_AUTO_EOI_EN
        if ((ack_state_q == A_P2) && (ack_state_d == A_IDLE) && aeoi_q) begin
            operation_d = {(operation_q[7] ? AUTOMATIC_ROTATING : NON_SPECIFIC_EOI),
                           operation_q[4:0]};
        end
`endif

        if (w_icw1) begin
            ltim_d      = D_IN[ICW1_LTIM];
            sngl_d      = D_IN[ICW1_SNGL];
            ic4_d       = D_IN[ICW1_IC4];
            im_d        = RESET_IMR;
            operation_d = '0;
        end else if (w_wr) begin
            unique case (cfg_state_q)
                S_ICW2: if (A0) t_d = D_IN[7:3];
                S_ICW4: if (A0) aeoi_d = D_IN[ICW4_AEOI];
                S_READY: begin
                    if (A0) begin
                        im_d = D_IN;
                    end else if (!D_IN[OCW3_SEL]) begin
                        operation_d = D_IN;
                    end else begin
                        rr_d  = D_IN[OCW3_RR];
                        ris_d = D_IN[OCW3_RIS];
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- output logic ----------------
    // INTA owns the bus from the first synced fall until the sequence ends
    assign w_read = CS & RD & (ack_state_q == A_IDLE) & (ack_state_d == A_IDLE);

    always_comb begin
        d_out_d = d_out_q;
        d_oe_d  = 1'b0;
        if ((ack_state_d == A_P2) && !w_inta_s) begin
            d_oe_d = 1'b1;
            if (ack_state_q != A_P2) begin
                d_out_d = {t_q, INT_VEC};
            end
        end else if (w_read) begin
            d_oe_d  = 1'b1;
            d_out_d = A0 ? im_q : (rr_q ? (ris_q ? ISR_IN : IRR_IN) : 8'h00);
        end
        int_d = (cfg_state_d == S_READY) & INT_REQ & (ack_state_d == A_IDLE);
    end

    assign D_OUT     = d_out_q;
    assign D_OE      = d_oe_q;
    assign IM        = im_q;
    assign OPERATION = operation_q;
    assign INT       = int_q;
    assign INIT_DONE = w_init_done;

endmodule
`default_nettype wire
